// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single physical-memory port between the I-cache and the D-cache.
//   One line transaction is in flight at a time. The D-cache wins ties, but a
//   streak counter hands the port to a waiting I-cache after MAX_D_STREAK
//   consecutive contested D grants. The winner's address and write data are
//   latched at grant, so the physical port sees stable values for the whole
//   transaction.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   i_pmem_read/address               I-cache line read request
//   i_pmem_rdata/resp                 data and one-cycle completion to the I-cache
//   d_pmem_read/write/address/wdata   D-cache line read / writeback request
//   d_pmem_rdata/resp                 data and one-cycle completion to the D-cache
//   pmem_read/write/address/wdata     physical memory request (latched)
//   pmem_rdata/resp                   physical memory data and completion
//   arb_busy                          high in every state except IDLE
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  arb_busy
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D_RD,
    SERVE_D_WR,
    RECOVER
  } state_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

  state_t                state;
  logic [3:0]            streak;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic contested;
  logic grant_i;
  logic grant_d;
  logic serving_d;

  assign i_req     = i_pmem_read;
  assign d_req     = d_pmem_read | d_pmem_write;
  assign contested = i_req & d_req;

  // D wins a contested grant until it has taken STREAK_LIMIT of them in a row;
  // an uncontested requester always wins.
  assign grant_d = d_req & (~i_req | (streak < STREAK_LIMIT));
  assign grant_i = i_req & ~grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      streak  <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            // A simultaneous read+write from the D-cache is executed as a write.
            state   <= d_pmem_write ? SERVE_D_WR : SERVE_D_RD;
            addr_q  <= d_pmem_address;
            wdata_q <= d_pmem_wdata;
            streak  <= contested ? streak + 4'd1 : 4'd0;
          end else if (grant_i) begin
            state   <= SERVE_I;
            addr_q  <= i_pmem_address;
            wdata_q <= '0;
            streak  <= 4'd0;
          end
        end
        SERVE_I, SERVE_D_RD, SERVE_D_WR: begin
          if (pmem_resp) state <= RECOVER;
        end
        // One dead cycle so a requester that drops its request after resp is
        // never granted a second time on a stale request.
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and responses are decoded from the state register so they never
  // follow requester inputs while a transaction is in flight.
  assign serving_d    = (state == SERVE_D_RD) || (state == SERVE_D_WR);
  assign pmem_read    = (state == SERVE_I) || (state == SERVE_D_RD);
  assign pmem_write   = (state == SERVE_D_WR);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign arb_busy     = (state != IDLE);

  assign i_pmem_resp  = (state == SERVE_I) && pmem_resp;
  assign d_pmem_resp  = serving_d && pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Self-checking bench for cache_mem_arbiter. A transaction-level model of the
//   arbiter predicts every output each cycle; directed scenarios add literal
//   expectations, then a long randomized phase (with occasional resets) runs.
module tb_cache_mem_arbiter;

  localparam int AW   = 16;
  localparam int LW   = 128;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          arb_busy;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .LINE_WIDTH  (LW),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .arb_busy      (arb_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkString(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // One call = one clock cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                               input logic [AW-1:0] da, input logic [LW-1:0] dwd,
                               input bit pr, input logic [LW-1:0] prd);
    @(posedge clk);
    #1;
    i_pmem_read    = ir;
    i_pmem_address = ia;
    d_pmem_read    = dr;
    d_pmem_write   = dw;
    d_pmem_address = da;
    d_pmem_wdata   = dwd;
    pmem_resp      = pr;
    pmem_rdata     = prd;
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model. The arbiter is described as "who owns
  // the port right now" plus a cool-down flag and a count of contested D wins.
  // ---------------------------------------------------------------------------
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_DRD  = 2;
  localparam int OWN_DWR  = 3;

  int            m_owner  = OWN_NONE;
  bit            m_cool   = 1'b0;
  int            m_streak = 0;
  logic [AW-1:0] m_addr   = '0;
  logic [LW-1:0] m_wdata  = '0;

  bit            e_rd, e_wr, e_busy, e_ir, e_dr;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_wd;
  bit            prev_strobe = 1'b0;
  string         dut_grants  = "";
  bit            want_i, want_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner  = OWN_NONE;
      m_cool   = 1'b0;
      m_streak = 0;
      m_addr   = '0;
      m_wdata  = '0;
    end
    e_rd   = (m_owner == OWN_I) || (m_owner == OWN_DRD);
    e_wr   = (m_owner == OWN_DWR);
    e_busy = (m_owner != OWN_NONE) || m_cool;
    e_addr = m_addr;
    e_wd   = m_wdata;
    e_ir   = (m_owner == OWN_I) && pmem_resp;
    e_dr   = ((m_owner == OWN_DRD) || (m_owner == OWN_DWR)) && pmem_resp;

    checkOutput("pmem_read",    LW'(pmem_read),    LW'(e_rd));
    checkOutput("pmem_write",   LW'(pmem_write),   LW'(e_wr));
    checkOutput("arb_busy",     LW'(arb_busy),     LW'(e_busy));
    checkOutput("pmem_address", LW'(pmem_address), LW'(e_addr));
    checkOutput("pmem_wdata",   pmem_wdata,        e_wd);
    checkOutput("i_pmem_resp",  LW'(i_pmem_resp),  LW'(e_ir));
    checkOutput("d_pmem_resp",  LW'(d_pmem_resp),  LW'(e_dr));
    checkOutput("i_pmem_rdata", i_pmem_rdata,      pmem_rdata);
    checkOutput("d_pmem_rdata", d_pmem_rdata,      pmem_rdata);

    // Log grants as seen on the DUT's physical port (I uses address 0x1111 in
    // the ordering scenarios).
    if ((pmem_read || pmem_write) && !prev_strobe)
      dut_grants = {dut_grants, (pmem_address == 16'h1111) ? "I" : "D"};
    prev_strobe = pmem_read || pmem_write;

    // Advance the model to the state it will hold after the coming edge.
    if (rst_n) begin
      if (m_owner != OWN_NONE) begin
        if (pmem_resp) begin
          m_owner = OWN_NONE;
          m_cool  = 1'b1;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else begin
        want_i = i_pmem_read;
        want_d = d_pmem_read || d_pmem_write;
        if (want_d && (!want_i || m_streak < MAXS)) begin
          m_owner  = d_pmem_write ? OWN_DWR : OWN_DRD;
          m_addr   = d_pmem_address;
          m_wdata  = d_pmem_wdata;
          m_streak = want_i ? m_streak + 1 : 0;
        end else if (want_i) begin
          m_owner  = OWN_I;
          m_addr   = i_pmem_address;
          m_wdata  = '0;
          m_streak = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_5a;
  logic [LW-1:0] wd1;
  logic [LW-1:0] wd2;

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_5a = {16{8'h5A}};
    wd1    = 128'h0123456789ABCDEF_FEDCBA9876543210;
    wd2    = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    rst_n = 1'b0;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",  LW'(arb_busy),     '0);
    checkOutput("reset_read",  LW'(pmem_read),    '0);
    checkOutput("reset_write", LW'(pmem_write),   '0);
    checkOutput("reset_addr",  LW'(pmem_address), '0);
    checkOutput("reset_wdata", pmem_wdata,        '0);
    rst_n = 1'b1;

    // I-only read of 0x1230, memory answers in the fourth serve cycle.
    applyStimulus(1, 16'h1230, 0, 0, '0, '0, 0, '0);
    #1 checkOutput("t1_c0_read", LW'(pmem_read), '0);
    applyStimulus(1, 16'h1230, 0, 0, '0, '0, 0, '0);
    #1 checkOutput("t1_c1_read", LW'(pmem_read), 1);
    checkOutput("t1_c1_addr", LW'(pmem_address), LW'(16'h1230));
    applyStimulus(1, 16'h1230, 0, 0, '0, '0, 0, '0);
    applyStimulus(1, 16'h1230, 0, 0, '0, '0, 0, '0);
    #1 checkOutput("t1_c3_read", LW'(pmem_read), 1);
    applyStimulus(1, 16'h1230, 0, 0, '0, '0, 1, pat_a5);
    #1 checkOutput("t1_c4_iresp", LW'(i_pmem_resp), 1);
    checkOutput("t1_c4_irdata", i_pmem_rdata, pat_a5);
    checkOutput("t1_c4_dresp", LW'(d_pmem_resp), '0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    #1 checkOutput("t1_c5_busy", LW'(arb_busy), 1);
    checkOutput("t1_c5_read", LW'(pmem_read), '0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    #1 checkOutput("t1_c6_busy", LW'(arb_busy), '0);

    // I and D together: D first, I after D's recovery.
    dut_grants = "";
    applyStimulus(1, 16'h1111, 1, 0, 16'h2222, '0, 0, '0);
    applyStimulus(1, 16'h1111, 1, 0, 16'h2222, '0, 1, pat_5a);
    #1 checkOutput("t2_d_addr", LW'(pmem_address), LW'(16'h2222));
    checkOutput("t2_dresp", LW'(d_pmem_resp), 1);
    checkOutput("t2_iresp_early", LW'(i_pmem_resp), '0);
    applyStimulus(1, 16'h1111, 0, 0, '0, '0, 0, '0);
    applyStimulus(1, 16'h1111, 0, 0, '0, '0, 0, '0);
    #1 checkOutput("t2_idle_read", LW'(pmem_read), '0);
    applyStimulus(1, 16'h1111, 0, 0, '0, '0, 1, pat_a5);
    #1 checkOutput("t2_i_addr", LW'(pmem_address), LW'(16'h1111));
    checkOutput("t2_iresp", LW'(i_pmem_resp), 1);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    checkString("t2_order", dut_grants, "DI");

    // D writeback of 0x4000 with the address changing mid-service.
    applyStimulus(0, '0, 0, 1, 16'h4000, wd1, 0, '0);
    applyStimulus(0, '0, 0, 1, 16'h5000, wd1, 0, '0);
    #1 checkOutput("t3_write", LW'(pmem_write), 1);
    checkOutput("t3_read", LW'(pmem_read), '0);
    checkOutput("t3_addr", LW'(pmem_address), LW'(16'h4000));
    checkOutput("t3_wdata", pmem_wdata, wd1);
    applyStimulus(0, '0, 0, 1, 16'h5000, wd1, 1, '0);
    #1 checkOutput("t3_dresp", LW'(d_pmem_resp), 1);
    checkOutput("t3_addr_hold", LW'(pmem_address), LW'(16'h4000));
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    #1 checkOutput("t3_dresp_once", LW'(d_pmem_resp), '0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);

    // Continuous contention with an always-ready memory: streak fairness.
    dut_grants = "";
    for (int c = 0; c < 30; c++)
      applyStimulus(1, 16'h1111, 1, 0, 16'h2222, '0, 1, pat_5a);
    repeat (3) applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    checkString("t4_order", dut_grants, "DDDDIDDDDI");

    // Reset during SERVE_D_RD abandons the transaction.
    applyStimulus(0, '0, 1, 0, 16'h7000, '0, 0, '0);
    applyStimulus(0, '0, 1, 0, 16'h7000, '0, 0, '0);
    #1 checkOutput("t5_read_pre", LW'(pmem_read), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    pmem_resp = 1'b1;
    #1 checkOutput("t5_read_rst", LW'(pmem_read), '0);
    checkOutput("t5_dresp_rst", LW'(d_pmem_resp), '0);
    checkOutput("t5_busy_rst", LW'(arb_busy), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d_pmem_read = 1'b0;
    pmem_resp = 1'b0;
    applyStimulus(1, 16'h3000, 0, 0, '0, '0, 0, '0);
    applyStimulus(1, 16'h3000, 0, 0, '0, '0, 1, pat_5a);
    #1 checkOutput("t5_i_addr", LW'(pmem_address), LW'(16'h3000));
    checkOutput("t5_iresp", LW'(i_pmem_resp), 1);
    checkOutput("t5_irdata", i_pmem_rdata, pat_5a);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);

    // Stray resp in IDLE, then a dual read+write request executed as a write.
    applyStimulus(0, '0, 0, 0, '0, '0, 1, pat_a5);
    #1 checkOutput("t6_stray_iresp", LW'(i_pmem_resp), '0);
    checkOutput("t6_stray_dresp", LW'(d_pmem_resp), '0);
    checkOutput("t6_stray_busy", LW'(arb_busy), '0);
    applyStimulus(0, '0, 1, 1, 16'h6000, wd2, 0, '0);
    applyStimulus(0, '0, 1, 1, 16'h6000, wd2, 0, '0);
    #1 checkOutput("t6_write", LW'(pmem_write), 1);
    checkOutput("t6_read", LW'(pmem_read), '0);
    checkOutput("t6_wdata", pmem_wdata, wd2);
    applyStimulus(0, '0, 1, 1, 16'h6000, wd2, 1, '0);
    #1 checkOutput("t6_dresp", LW'(d_pmem_resp), 1);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      applyStimulus($urandom_range(0, 99) < 60, AW'($urandom),
                    $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30,
                    AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 99) < 35, {$urandom, $urandom, $urandom, $urandom});
    end
    applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port between the I-cache (fetch-stage miss path) and the D-cache (memory-stage miss and writeback path) of the pipelined LC-3b CPU.
- Serves one line transaction at a time. D-cache has priority by default; a streak counter keeps the I-cache from being starved.
- Latches address and write data at grant, so the physical port sees stable values for the whole transaction.

Parameters:
- ADDR_WIDTH, 16, physical byte address width.
- LINE_WIDTH, 128, cache line width in bits.
- MAX_D_STREAK, 4, number of consecutive D grants allowed while I is waiting. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_pmem_read  in  1  I-cache line read request.
- i_pmem_address  in  ADDR_WIDTH  I-cache line address.
- i_pmem_rdata  out  LINE_WIDTH  line data returned to the I-cache.
- i_pmem_resp  out  1  one-cycle completion pulse to the I-cache.
- d_pmem_read  in  1  D-cache line read request.
- d_pmem_write  in  1  D-cache line write (writeback) request.
- d_pmem_address  in  ADDR_WIDTH  D-cache line address.
- d_pmem_wdata  in  LINE_WIDTH  D-cache writeback data.
- d_pmem_rdata  out  LINE_WIDTH  line data returned to the D-cache.
- d_pmem_resp  out  1  one-cycle completion pulse to the D-cache.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_WIDTH  physical memory address (latched).
- pmem_wdata  out  LINE_WIDTH  physical memory write data (latched).
- pmem_rdata  in  LINE_WIDTH  physical memory read data.
- pmem_resp  in  1  physical memory completion.
- arb_busy  out  1  high in every state except IDLE.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE, streak = 0.
  - Address and wdata latches = 0.
  - pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, arb_busy all = 0.
- Reset asserted mid-transaction: the transaction is abandoned immediately, no resp is issued, and the block returns to IDLE.
- States: IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR, RECOVER.
- IDLE arbitration, evaluated each cycle; the grant takes effect at the next clk edge:
  - Only I requesting -> SERVE_I.
  - Only D requesting -> SERVE_D_RD, or SERVE_D_WR if d_pmem_write.
  - Both requesting, streak < MAX_D_STREAK -> D state; streak increments.
  - Both requesting, streak == MAX_D_STREAK -> SERVE_I.
  - Any I grant clears streak. A D grant with I idle clears streak.
  - d_pmem_read and d_pmem_write both high is a protocol error and is treated as a write.
- At the grant edge, pmem_address and pmem_wdata are latched from the winner. For an I grant, wdata latches 0.
- SERVE_* states:
  - pmem_read = 1 in SERVE_I and SERVE_D_RD; pmem_write = 1 in SERVE_D_WR. Strobes are decoded from the state register, not combinationally from requester inputs.
  - Strobes stay high until pmem_resp.
  - Requester input changes or deassertion while serving are ignored; the latched transaction completes.
- Completion, in the cycle pmem_resp = 1 in SERVE_x:
  - The owner's *_resp = 1 combinationally, for that cycle only.
  - *_rdata = pmem_rdata in that cycle. rdata outputs are a pass-through of pmem_rdata at all times.
  - Next state = RECOVER.
- RECOVER lasts exactly 1 cycle, with no strobes and no arbitration, so that a requester dropping its request after resp is never double-served. Then IDLE.
- Minimum request-to-resp latency: request in cycle 0, strobe in cycle 1, resp no earlier than cycle 1 (pmem_resp in cycle 1).
- Back-to-back request spacing: 2 idle-side cycles (RECOVER, then IDLE).
- pmem_resp outside the SERVE_* states is ignored.
- streak width is 4 bits and saturates at MAX_D_STREAK.

Test Plan:
- Reset then I-only read of 0x1230; memory responds after 3 cycles with 128'hA5..A5 -> pmem_read high for cycles 1-4, pmem_address=0x1230, i_pmem_resp pulses once with that data, d_pmem_resp stays 0, arb_busy falls after RECOVER.
- I and D read asserted together in IDLE -> D is served first (pmem_address = D address). I is served only after D's RECOVER and IDLE, as long as I holds its request.
- D writeback of 0x4000 with wdata 128'h0123...; D changes address to 0x5000 mid-service -> pmem_write=1, pmem_address stays 0x4000, pmem_read=0, exactly one d_pmem_resp.
- D requests continuously while I requests continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; streak never exceeds 4.
- rst_n pulled low during SERVE_D_RD, before pmem_resp -> strobes drop immediately, no resp pulse. After release, a new I request is served normally.
- Stray pmem_resp in IDLE, plus d_pmem_read and d_pmem_write both high -> the stray resp produces no resp pulse; the dual request is executed as a write.
